// File: rtl/cpu_pkg.sv
// Shared definitions for the EX-stage shift unit: shift op encodings and FSM states.
package cpu_pkg;

  // Shift operation encodings as presented on the op port
  localparam logic [1:0] SH_SLL  = 2'b00;
  localparam logic [1:0] SH_SRL  = 2'b01;
  localparam logic [1:0] SH_SRA  = 2'b10;
  localparam logic [1:0] SH_PASS = 2'b11;

  // Control states of the multi-cycle shifter
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shift_step.sv
// Single-bit shift step: applies one position of the selected shift to the working value.
module shift_step
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] w,
  output logic [WIDTH-1:0] w_next
);

  // Per-op rule; SRA replicates the sign bit so it survives every step
  always_comb begin
    w_next = w;
    case (op)
      SH_SLL:  w_next = {w[WIDTH-2:0], 1'b0};
      SH_SRL:  w_next = {1'b0, w[WIDTH-1:1]};
      SH_SRA:  w_next = {w[WIDTH-1], w[WIDTH-1:1]};
      default: w_next = w;
    endcase
  end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle shifter for SLL/SRL/SRA and variable forms; one bit per clock with start/busy/done.
module seq_shift_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   work;
  logic [WIDTH-1:0]   work_step;
  logic [1:0]         op_q;
  logic [SHAMT_W-1:0] count;
  logic               accept;
  logic               zero_len;

  // One-bit step of the working register using the op latched at acceptance
  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .op     (op_q),
    .w      (work),
    .w_next (work_step)
  );

  // State register; reset aborts any shift in flight without a done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: requests are taken in IDLE and DONE, never during SHIFT
  always_comb begin
    accept     = 1'b0;
    zero_len   = 1'b0;
    state_next = state;
    accept     = start && (state != SHIFT);
    zero_len   = (shamt == '0) || (op == SH_PASS);
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          state_next = zero_len ? DONE : SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
        if (count == SHAMT_W'(1)) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: load operands on acceptance, otherwise step and count down while shifting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work  <= '0;
      op_q  <= SH_SLL;
      count <= '0;
    end else if (accept) begin
      work  <= data_in;
      op_q  <= op;
      count <= shamt;
    end else if (state == SHIFT) begin
      work  <= work_step;
      count <= count - SHAMT_W'(1);
    end
  end

  // Handshake outputs are pure decodes of the state; result is the working register
  always_comb begin
    busy   = (state == SHIFT);
    done   = (state == DONE);
    result = work;
  end

endmodule
